// File: rtl/a2_task_serializer.sv
// Parallel-to-serial converter: sends the top N bits of a captured word MSB first.
// Lengths below 3 are discarded without any output activity.
module a2_task_serializer #(
  parameter int WIDTH    = 8,
  parameter int VAL_BITS = 3
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                data_val_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic [VAL_BITS-1:0] data_mod_i,
  output logic                ser_data_val_o,
  output logic                ser_data_o,
  output logic                busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    len_reg;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    len_clamped;
  logic             accept;

  // Requested lengths beyond the word width are limited to the full word.
  always_comb begin
    if (32'(data_mod_i) > WIDTH) begin
      len_clamped = CW'(WIDTH);
    end else begin
      len_clamped = CW'(data_mod_i);
    end
  end

  assign accept = data_val_i && (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (len_clamped >= CW'(3))) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (bit_cnt == (len_reg - CW'(1))) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The current bit is always the shift register MSB; it shifts once per sent bit.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shift_reg <= '0;
      len_reg   <= '0;
      bit_cnt   <= '0;
    end else if (accept) begin
      shift_reg <= data_i;
      len_reg   <= len_clamped;
      bit_cnt   <= '0;
    end else if (state == SEND) begin
      shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      bit_cnt   <= bit_cnt + CW'(1);
    end
  end

  always_comb begin
    ser_data_val_o = 1'b0;
    ser_data_o     = 1'b0;
    busy_o         = 1'b0;
    if (state == SEND) begin
      ser_data_val_o = 1'b1;
      ser_data_o     = shift_reg[WIDTH-1];
      busy_o         = 1'b1;
    end
  end

endmodule

// File: tb/tb_a2_task_serializer.sv
// Self-checking bench for a2_task_serializer: directed vector table, corner sequences
// and a max-rate random stream checked against a word-level reference queue.
module tb_a2_task_serializer;

  localparam int WIDTH    = 8;
  localparam int VAL_BITS = 3;

  logic                clk;
  logic                srst_i;
  logic                data_val_i;
  logic [WIDTH-1:0]    data_i;
  logic [VAL_BITS-1:0] data_mod_i;
  logic                ser_data_val_o;
  logic                ser_data_o;
  logic                busy_o;

  typedef struct {
    int               len;
    logic [WIDTH-1:0] word;
    int               start;
  } word_t;

  typedef struct {
    logic [WIDTH-1:0]    data;
    logic [VAL_BITS-1:0] mod;
    int                  exp_len;
    logic [WIDTH-1:0]    exp_word;
  } vec_t;

  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               last_accept = 0;
  int               acc_len = 0;
  int               acc_start = 0;
  logic [WIDTH-1:0] acc_word = '0;
  word_t            outq[$];
  word_t            expq[$];
  vec_t             vecs[7];

  a2_task_serializer #(.WIDTH(WIDTH), .VAL_BITS(VAL_BITS)) dut (
    .clk_i          (clk),
    .srst_i         (srst_i),
    .data_val_i     (data_val_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .ser_data_val_o (ser_data_val_o),
    .ser_data_o     (ser_data_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reassemble serial bits into MSB-aligned words and check per-cycle output rules.
  always @(negedge clk) begin
    checks++;
    if (busy_o !== ser_data_val_o) begin
      errors++;
      $display("[TB] FAIL busy_eq_val cycle %0d: busy_o=%b ser_data_val_o=%b", cyc, busy_o, ser_data_val_o);
    end
    checks++;
    if (ser_data_val_o !== 1'b1 && ser_data_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_data_zero cycle %0d: ser_data_o=%b required 0", cyc, ser_data_o);
    end
    if (ser_data_val_o === 1'b1) begin
      if (acc_len == 0) acc_start = cyc;
      if (acc_len < WIDTH) acc_word[WIDTH-1-acc_len] = ser_data_o;
      acc_len++;
    end else if (acc_len > 0) begin
      outq.push_back('{acc_len, acc_word, acc_start});
      acc_len  = 0;
      acc_word = '0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Compares the words collected since the last call against zero or one expected word.
  task automatic checkWords(input string name, input int exp_len, input logic [WIDTH-1:0] exp_word,
                            input int exp_start);
    if (exp_len == 0) begin
      checkOutput({name, "_nwords"}, outq.size(), 0);
    end else begin
      checkOutput({name, "_nwords"}, outq.size(), 1);
      if (outq.size() > 0) begin
        checkOutput({name, "_len"}, outq[0].len, exp_len);
        checkOutput({name, "_word"}, int'(outq[0].word), int'(exp_word));
        checkOutput({name, "_latency"}, outq[0].start, exp_start);
      end
    end
    outq.delete();
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [VAL_BITS-1:0] m);
    @(negedge clk);
    data_val_i  = 1'b1;
    data_i      = d;
    data_mod_i  = m;
    last_accept = cyc + 1;
    @(negedge clk);
    data_val_i = 1'b0;
    data_i     = '0;
    data_mod_i = '0;
  endtask

  initial begin
    int sent;
    int n;
    logic [WIDTH-1:0] d;
    logic [VAL_BITS-1:0] m;

    vecs[0] = '{8'hB2, 3'd0, 0, 8'h00};
    vecs[1] = '{8'hD6, 3'd5, 5, 8'hD0};
    vecs[2] = '{8'h5A, 3'd1, 0, 8'h00};
    vecs[3] = '{8'h7E, 3'd2, 0, 8'h00};
    vecs[4] = '{8'hA5, 3'd3, 3, 8'hA0};
    vecs[5] = '{8'h3C, 3'd7, 7, 8'h3C};
    vecs[6] = '{8'h81, 3'd6, 6, 8'h80};

    srst_i     = 1'b1;
    data_val_i = 1'b0;
    data_i     = '0;
    data_mod_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_val", int'(ser_data_val_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_data", int'(ser_data_o), 0);
    srst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].data, vecs[i].mod);
      repeat (WIDTH + 2) @(negedge clk);
      checkWords($sformatf("vec%0d", i), vecs[i].exp_len, vecs[i].exp_word, last_accept);
    end

    // A word offered while busy must not disturb or follow the active transfer.
    applyStimulus(8'hFF, 3'd7);
    @(negedge clk);
    data_val_i = 1'b1;
    data_i     = 8'h00;
    data_mod_i = 3'd3;
    @(negedge clk);
    data_val_i = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    checkWords("busy_reject", 7, 8'hFE, last_accept);

    // Reset during the third bit, held one extra cycle alongside a valid input.
    applyStimulus(8'hE4, 3'd6);
    @(negedge clk);
    @(negedge clk);
    srst_i     = 1'b1;
    data_val_i = 1'b1;
    data_i     = 8'hFF;
    data_mod_i = 3'd5;
    @(negedge clk);
    checkOutput("rst_abort_val", int'(ser_data_val_o), 0);
    checkOutput("rst_abort_busy", int'(busy_o), 0);
    @(negedge clk);
    checkOutput("rst_priority_val", int'(ser_data_val_o), 0);
    srst_i     = 1'b0;
    data_val_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_priority_busy", int'(busy_o), 0);
    checkWords("rst_partial", 3, 8'hE0, last_accept);
    applyStimulus(8'h9B, 3'd4);
    repeat (WIDTH + 2) @(negedge clk);
    checkWords("after_reset", 4, 8'h90, last_accept);

    // Max-rate random stream: offer a new word whenever busy_o is low.
    sent = 0;
    while (sent < 128) begin
      @(negedge clk);
      if (busy_o == 1'b0) begin
        d          = WIDTH'($urandom);
        m          = VAL_BITS'($urandom_range(0, 7));
        data_val_i = 1'b1;
        data_i     = d;
        data_mod_i = m;
        n          = (int'(m) > WIDTH) ? WIDTH : int'(m);
        if (n >= 3) expq.push_back('{n, WIDTH'((int'(d) >> (WIDTH - n)) << (WIDTH - n)), 0});
        sent++;
      end else begin
        data_val_i = 1'($urandom_range(0, 1));
        data_i     = WIDTH'($urandom);
        data_mod_i = VAL_BITS'($urandom);
      end
    end
    @(negedge clk);
    data_val_i = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("rand_nwords", outq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      checkOutput($sformatf("rand%0d_len", i), outq[i].len, expq[i].len);
      checkOutput($sformatf("rand%0d_word", i), int'(outq[i].word), int'(expq[i].word));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
